// File: rtl/i2c_target_pkg.sv
// Shared I2C definitions and target FSM state encoding.
// Bus-level constants are common to the controller and the target.
package i2c_target_pkg;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_RD_NEXT,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with one-cycle edge, START and STOP pulses.
// Flops reset high so an idle bus produces no edges out of reset.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic s_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic s_scl;
  logic p_scl;
  logic p_sda;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
      p_scl <= 1'b1;
      p_sda <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl_in};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda_in};
      p_scl <= s_scl;
      p_sda <= s_sda;
    end
  end

  assign s_scl     = scl_q[SYNC_STAGES-1];
  assign s_sda     = sda_q[SYNC_STAGES-1];
  assign scl_rise  = s_scl & ~p_scl;
  assign scl_fall  = ~s_scl & p_scl;
  assign start_det = p_sda & ~s_sda & s_scl;
  assign stop_det  = ~p_sda & s_sda & s_scl;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, pointer/data writes and
// auto-incrementing reads onto a byte-wide register port.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h52,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic s_sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .s_sda    (s_sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t     state, state_d;
  logic [2:0] bit_ctr, bit_ctr_d;
  logic [7:0] shift, shift_d;
  logic       rw, rw_d;
  logic       sda_out_d;
  logic [7:0] reg_addr_d;
  logic [7:0] reg_wdata_d;
  logic       reg_we_d;
  logic       reg_re_d;
  logic       busy_d;

  logic [7:0] byte_in;
  logic       last;
  logic       rx_state;

  assign byte_in  = {shift[6:0], s_sda};
  assign last     = (bit_ctr == 3'd7);
  assign rx_state = (state == S_ADDR) || (state == S_PTR)
                 || (state == S_WDATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_ctr   <= 3'd0;
      shift     <= 8'd0;
      rw        <= RW_WRITE;
      sda_out   <= 1'b1;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      bit_ctr   <= bit_ctr_d;
      shift     <= shift_d;
      rw        <= rw_d;
      sda_out   <= sda_out_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_we    <= reg_we_d;
      reg_re    <= reg_re_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state;
    bit_ctr_d   = bit_ctr;
    shift_d     = shift;
    rw_d        = rw;
    sda_out_d   = sda_out;
    reg_addr_d  = reg_we ? reg_addr + 8'd1 : reg_addr;
    reg_wdata_d = reg_wdata;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_ctr_d = 3'd0;
      sda_out_d = 1'b1;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      if (rx_state && scl_rise) begin
        shift_d   = byte_in;
        bit_ctr_d = bit_ctr + 3'd1;
      end
      unique case (state)
        S_IDLE: ;
        S_ADDR:
          if (scl_rise && last) begin
            if (byte_in[7:1] == TARGET_ADDR) begin
              rw_d    = byte_in[0];
              busy_d  = 1'b1;
              state_d = S_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IGNORE;
            end
          end
        S_PTR:
          if (scl_rise && last) begin
            reg_addr_d = byte_in;
            state_d    = S_PTR_ACK;
          end
        S_WDATA:
          if (scl_rise && last) begin
            reg_wdata_d = byte_in;
            reg_we_d    = 1'b1;
            state_d     = S_WDATA_ACK;
          end
        // sda_out doubles as the ACK phase: first fall drives, second ends
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK:
          if (scl_fall) begin
            if (sda_out) begin
              sda_out_d = ACK;
            end else begin
              sda_out_d = 1'b1;
              bit_ctr_d = 3'd0;
              if (state == S_ADDR_ACK && rw == RW_READ) begin
                reg_re_d = 1'b1;
                state_d  = S_RDATA;
              end else if (state == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        S_RDATA:
          if (reg_re) begin
            shift_d   = reg_rdata;
            sda_out_d = reg_rdata[7];
          end else if (scl_fall) begin
            shift_d   = {shift[6:0], 1'b0};
            sda_out_d = shift[6];
          end else if (scl_rise) begin
            bit_ctr_d = bit_ctr + 3'd1;
            if (last) state_d = S_RDATA_ACK;
          end
        S_RDATA_ACK:
          if (scl_fall) begin
            sda_out_d = 1'b1;
          end else if (scl_rise) begin
            if (s_sda == ACK) begin
              reg_addr_d = reg_addr + 8'd1;
              state_d    = S_RD_NEXT;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IGNORE;
            end
          end
        S_RD_NEXT:
          if (scl_fall) begin
            reg_re_d  = 1'b1;
            bit_ctr_d = 3'd0;
            state_d   = S_RDATA;
          end
        S_IGNORE: sda_out_d = 1'b1;
        default:  state_d = S_IDLE;
      endcase
    end
  end

endmodule
